// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: reads a whole frame from the 16-bit frame buffer port in
// raster order and emits it as a valid/ready pixel stream with SOP/EOP framing.
// A small first-word-fall-through FIFO decouples the fixed-latency RAM from the sink.
module framebuffer_scanout #(
    parameter int H_RES      = 400,
    parameter int V_RES      = 240,
    parameter int ADDR_W     = 17,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    input  logic [15:0]       mem_readdata,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              frame_done
);

    localparam int                NPIX     = H_RES * V_RES;
    localparam int                CNT_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   pix_cnt;
    logic               issue;
    logic               cs_sop;
    logic               cs_eop;
    logic               inflight;
    logic               inflight_sop;
    logic               inflight_eop;
    logic [17:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fifo_count;
    logic [PTR_W+1:0]   occupancy;
    logic               credit;
    logic               drained;
    logic               push;
    logic               pop;
    logic               head_sop;
    logic               head_eop;

    assign mem_clken = 1'b1;

    // A slot is reserved for every read on the bus or returning, so a new read
    // is only requested when buffered + outstanding pixels leave room for it.
    assign occupancy = (PTR_W+2)'(fifo_count) + (PTR_W+2)'(inflight) + (PTR_W+2)'(mem_chipselect);
    assign credit    = occupancy < (PTR_W+2)'(FIFO_DEPTH);
    assign drained   = (fifo_count == '0) && !inflight && !mem_chipselect;

    assign push      = inflight;
    assign pop       = out_valid && out_ready;
    assign out_valid = (fifo_count != '0);
    assign {head_sop, head_eop, out_data} = fifo_mem[rd_ptr];
    assign out_sop   = out_valid && head_sop;
    assign out_eop   = out_valid && head_eop;

    // State register of the frame sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and read-request decision; the request lands on the RAM bus next cycle.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = FETCH;
                    issue      = credit;
                end
            end
            FETCH: begin
                issue = credit;
            end
            DRAIN: begin
                if (drained) begin
                    if (enable) begin
                        state_next = FETCH;
                        issue      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (issue && (pix_cnt == LAST_PIX)) begin
            state_next = DRAIN;
        end
    end

    // Registered RAM request: address tracks the pixel counter, tags travel with the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_chipselect <= 1'b0;
            mem_address    <= BASE;
            cs_sop         <= 1'b0;
            cs_eop         <= 1'b0;
            pix_cnt        <= '0;
        end else begin
            mem_chipselect <= issue;
            mem_address    <= BASE + ADDR_W'(pix_cnt);
            cs_sop         <= (pix_cnt == '0);
            cs_eop         <= (pix_cnt == LAST_PIX);
            if (issue) begin
                pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
            end
        end
    end

    // In-flight flag marks the cycle when RAM data for last cycle's read is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
        end else begin
            inflight     <= mem_chipselect;
            inflight_sop <= cs_sop;
            inflight_eop <= cs_eop;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every use.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {inflight_sop, inflight_eop, mem_readdata};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // One-cycle pulse after the last pixel of a frame is taken by the sink.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && head_eop;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: self-checking bench with a 1-cycle-latency RAM model and a
// stream-level reference model of the expected raster pixel sequence.
module tb_framebuffer_scanout;

    localparam int NPIX = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [16:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    int exp_idx  = 0;
    int rd_idx   = 0;
    int issued   = 0;
    int accepted = 0;
    int frames   = 0;
    int sop_seen = 0;
    logic        fd_exp   = 1'b0;
    logic        stall_q  = 1'b0;
    logic [15:0] held_data;
    logic        held_sop;
    logic        held_eop;
    logic        rst_q;

    framebuffer_scanout #(
        .H_RES(4), .V_RES(3), .ADDR_W(17), .BASE_ADDR(0), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .mem_address(mem_address),
        .mem_chipselect(mem_chipselect),
        .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .frame_done(frame_done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // RAM model: word[i] = A000+i, data returned the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            mem_readdata <= 16'hA000 + mem_address[15:0];
        end else begin
            mem_readdata <= 16'hDEAD;
        end
    end

    // Remember whether reset was sampled at the last edge.
    always @(posedge clk) begin
        rst_q <= reset;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic rdy);
        @(posedge clk);
        #1;
        reset     = r;
        enable    = e;
        out_ready = rdy;
    endtask

    task automatic waitSample();
        @(negedge clk);
        #1;
    endtask

    // Compare the DUT against the stream model on every cycle.
    always @(negedge clk) begin
        logic [15:0] exp_data;
        if (rst_q === 1'b1) begin
            checkOutput("rst_valid", {31'b0, out_valid}, 0);
            checkOutput("rst_sop", {31'b0, out_sop}, 0);
            checkOutput("rst_eop", {31'b0, out_eop}, 0);
            checkOutput("rst_cs", {31'b0, mem_chipselect}, 0);
            checkOutput("rst_addr", {15'b0, mem_address}, 0);
            checkOutput("rst_frame_done", {31'b0, frame_done}, 0);
            exp_idx  = 0;
            rd_idx   = 0;
            issued   = 0;
            accepted = 0;
            fd_exp   = 1'b0;
            stall_q  = 1'b0;
        end else if (rst_q === 1'b0) begin
            if (mem_chipselect) begin
                checkOutput("rd_addr", {15'b0, mem_address}, rd_idx);
                rd_idx = (rd_idx + 1) % NPIX;
                issued++;
            end
            checkOutput("buffer_bound", {31'b0, (issued - accepted) <= 4}, 1);
            checkOutput("frame_done", {31'b0, frame_done}, {31'b0, fd_exp});
            if (frame_done) begin
                frames++;
            end
            if (stall_q) begin
                checkOutput("hold_valid", {31'b0, out_valid}, 1);
                checkOutput("hold_data", {16'b0, out_data}, {16'b0, held_data});
                checkOutput("hold_sop", {31'b0, out_sop}, {31'b0, held_sop});
                checkOutput("hold_eop", {31'b0, out_eop}, {31'b0, held_eop});
            end
            fd_exp = 1'b0;
            if (out_valid && out_ready) begin
                exp_data = 16'hA000 + 16'(exp_idx);
                checkOutput("pix_data", {16'b0, out_data}, {16'b0, exp_data});
                checkOutput("pix_sop", {31'b0, out_sop}, {31'b0, exp_idx == 0});
                checkOutput("pix_eop", {31'b0, out_eop}, {31'b0, exp_idx == NPIX - 1});
                if (out_sop) begin
                    sop_seen++;
                end
                fd_exp  = (exp_idx == NPIX - 1);
                exp_idx = (exp_idx + 1) % NPIX;
                accepted++;
            end
            stall_q   = out_valid && !out_ready;
            held_data = out_data;
            held_sop  = out_sop;
            held_eop  = out_eop;
        end
    end

    // Directed scenarios followed by a randomized back-pressure run.
    initial begin
        int          lat;
        int          run;
        int          n;
        int          base;
        int          f0;
        int          a0;
        int          s0;
        logic        seen_cs;
        logic        seen_valid;
        logic [15:0] last_data;
        logic        last_eop;

        reset     = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);

        // 1: single frame at full rate, latency and framing
        applyStimulus(1'b0, 1'b1, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("t1_latency", lat, 3);
        checkOutput("t1_first_data", {16'b0, out_data}, 32'hA000);
        checkOutput("t1_first_sop", {31'b0, out_sop}, 1);
        enable    = 1'b0;
        run       = 0;
        last_data = 16'h0;
        last_eop  = 1'b0;
        while (out_valid && run < 40) begin
            last_data = out_data;
            last_eop  = out_eop;
            run++;
            @(negedge clk);
        end
        checkOutput("t1_run_length", run, 12);
        checkOutput("t1_last_data", {16'b0, last_data}, 32'hA00B);
        checkOutput("t1_last_eop", {31'b0, last_eop}, 1);
        seen_cs = 1'b0;
        repeat (20) begin
            waitSample();
            seen_cs = seen_cs | mem_chipselect;
        end
        checkOutput("t1_frames", frames, 1);
        checkOutput("t1_idle_cs", {31'b0, seen_cs}, 0);

        // 2: twenty-cycle stall mid-frame
        f0 = frames;
        applyStimulus(1'b0, 1'b1, 1'b1);
        base = accepted;
        n = 0;
        while (accepted < base + 5 && n < 100) begin
            waitSample();
            n++;
        end
        checkOutput("t2_reach_timeout", {31'b0, n < 100}, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (20) waitSample();
        checkOutput("t2_cs_drop", {31'b0, mem_chipselect}, 0);
        checkOutput("t2_buffered", issued - accepted, 4);
        checkOutput("t2_valid_held", {31'b0, out_valid}, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        n = 0;
        while (frames < f0 + 1 && n < 200) begin
            waitSample();
            n++;
        end
        checkOutput("t2_frame_timeout", {31'b0, n < 200}, 1);

        // 3: three back-to-back frames
        f0 = frames;
        a0 = accepted;
        s0 = sop_seen;
        n  = 0;
        while (frames < f0 + 3 && n < 500) begin
            waitSample();
            n++;
        end
        checkOutput("t3_timeout", {31'b0, n < 500}, 1);
        checkOutput("t3_pixels", accepted - a0, 36);
        checkOutput("t3_sops", sop_seen - s0, 3);

        // 4: enable dropped after pixel 5, frame still completes
        n = 0;
        while (exp_idx != 6 && n < 100) begin
            waitSample();
            n++;
        end
        checkOutput("t4_reach_timeout", {31'b0, n < 100}, 1);
        enable = 1'b0;
        f0 = frames;
        n  = 0;
        while (frames < f0 + 1 && n < 100) begin
            waitSample();
            n++;
        end
        checkOutput("t4_frame_timeout", {31'b0, n < 100}, 1);
        checkOutput("t4_frame_complete", exp_idx, 0);
        seen_cs    = 1'b0;
        seen_valid = 1'b0;
        repeat (20) begin
            waitSample();
            seen_cs    = seen_cs | mem_chipselect;
            seen_valid = seen_valid | out_valid;
        end
        checkOutput("t4_idle_cs", {31'b0, seen_cs}, 0);
        checkOutput("t4_idle_valid", {31'b0, seen_valid}, 0);

        // 5: reset with a read in flight and the FIFO half full
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        waitSample();
        checkOutput("t5_pre_valid", {31'b0, out_valid}, 1);
        checkOutput("t5_pre_cs", {31'b0, mem_chipselect}, 1);
        reset = 1'b1;
        waitSample();
        checkOutput("t5_valid_after_reset", {31'b0, out_valid}, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            waitSample();
            n++;
        end
        checkOutput("t5_restart_timeout", {31'b0, n < 20}, 1);
        checkOutput("t5_first_data", {16'b0, out_data}, 32'hA000);
        checkOutput("t5_first_sop", {31'b0, out_sop}, 1);
        enable = 1'b0;
        f0 = frames;
        n  = 0;
        while (frames < f0 + 1 && n < 100) begin
            waitSample();
            n++;
        end
        checkOutput("t5_frame_timeout", {31'b0, n < 100}, 1);
        repeat (10) waitSample();

        // 6: random back-pressure over ten frames
        f0 = frames;
        a0 = accepted;
        applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        n = 0;
        while (frames < f0 + 10 && n < 4000) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        checkOutput("t6_timeout", {31'b0, n < 4000}, 1);
        checkOutput("t6_pixels", accepted - a0, 120);
        enable = 1'b0;
        n = 0;
        while (frames < f0 + 11 && n < 400) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        checkOutput("t6_tail_timeout", {31'b0, n < 400}, 1);
        out_ready = 1'b1;
        repeat (10) waitSample();
        checkOutput("t6_idle_valid", {31'b0, out_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
